// File: rtl/soc_data_port_arbiter.sv
// soc_data_port_arbiter
//   Purpose : shares one OBI-style data port (req/gnt/rvalid) between N_REQ requesters.
//             Round-robin arbitration, selection locked until granted, in-order response routing.
//   Ports   : clk_i/reset_i (async, active-high); per-requester req/we/be/addr/wdata in, gnt/rvalid out;
//             rdata_o broadcast; mst_* is the shared downstream port; rsp_err_o is a sticky
//             "response with nothing outstanding" flag.
module soc_data_port_arbiter #(
  parameter int N_REQ           = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [N_REQ-1:0]                req_i,
  input  logic [N_REQ-1:0]                we_i,
  input  logic [N_REQ*(DATA_WIDTH/8)-1:0] be_i,
  input  logic [N_REQ*ADDR_WIDTH-1:0]     addr_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]     wdata_i,
  output logic [N_REQ-1:0]                gnt_o,
  output logic [N_REQ-1:0]                rvalid_o,
  output logic [DATA_WIDTH-1:0]           rdata_o,
  output logic                            mst_req_o,
  input  logic                            mst_gnt_i,
  output logic                            mst_we_o,
  output logic [DATA_WIDTH/8-1:0]         mst_be_o,
  output logic [ADDR_WIDTH-1:0]           mst_addr_o,
  output logic [DATA_WIDTH-1:0]           mst_wdata_o,
  input  logic                            mst_rvalid_i,
  input  logic [DATA_WIDTH-1:0]           mst_rdata_i,
  output logic                            rsp_err_o
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   own_mem_q [MAX_OUTSTANDING];
  logic [IDX_W-1:0]   own_mem_d [MAX_OUTSTANDING];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               rsp_err_q, rsp_err_d;

  logic [IDX_W:0]     cand_sum;
  logic [IDX_W:0]     rr_sum;
  logic [IDX_W-1:0]   rr_winner;
  logic               found;
  logic [IDX_W-1:0]   sel;
  logic [IDX_W-1:0]   drive_idx;
  logic               sel_req;
  logic               full;
  logic               hs;
  logic               pop;

  // Round-robin scan starting at rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    rr_winner = '0;
    found     = 1'b0;
    cand_sum  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (cand_sum >= (IDX_W+1)'(N_REQ)) cand_sum = cand_sum - (IDX_W+1)'(N_REQ);
      if (!found && req_i[cand_sum[IDX_W-1:0]]) begin
        found     = 1'b1;
        rr_winner = cand_sum[IDX_W-1:0];
      end
    end
  end

  // Full uses the registered count, so a same-cycle pop cannot open a slot.
  assign full      = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign sel       = (state_q == HOLD) ? owner_q : rr_winner;
  assign sel_req   = (state_q == HOLD) ? req_i[owner_q] : |req_i;
  assign mst_req_o = sel_req & ~full;
  assign hs        = mst_req_o & mst_gnt_i;
  assign pop       = mst_rvalid_i & (count_q != '0);
  assign drive_idx = mst_req_o ? sel : '0;
  assign rdata_o   = mst_rdata_i;
  assign rsp_err_o = rsp_err_q;

  // Request payload mux; slice 0 when idle.
  always_comb begin
    mst_we_o    = 1'b0;
    mst_be_o    = '0;
    mst_addr_o  = '0;
    mst_wdata_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (drive_idx == IDX_W'(k)) begin
        mst_we_o    = we_i[k];
        mst_be_o    = be_i[k*BE_W +: BE_W];
        mst_addr_o  = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        mst_wdata_o = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (hs) gnt_o[sel] = 1'b1;
    rvalid_o = '0;
    if (pop) rvalid_o[own_mem_q[rd_ptr_q]] = 1'b1;
  end

  // FSM and round-robin pointer. The lock only releases on handshake or on the
  // owner withdrawing its request; a full FIFO leaves the lock in place.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    rr_sum   = {1'b0, sel} + (IDX_W+1)'(1);
    case (state_q)
      IDLE: begin
        if (mst_req_o && !mst_gnt_i) begin
          state_d = HOLD;
          owner_d = sel;
        end
      end
      HOLD: begin
        if (hs || !req_i[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (hs) begin
      rr_ptr_d = (rr_sum >= (IDX_W+1)'(N_REQ)) ? '0 : rr_sum[IDX_W-1:0];
    end
  end

  // Owner FIFO: records who was granted so responses route in grant order.
  always_comb begin
    own_mem_d = own_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rsp_err_d = rsp_err_q | (mst_rvalid_i & (count_q == '0));
    if (hs) begin
      own_mem_d[wr_ptr_q] = sel;
      wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_OUTSTANDING-1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUTSTANDING-1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({hs, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rsp_err_q <= 1'b0;
      for (int m = 0; m < MAX_OUTSTANDING; m++) own_mem_q[m] <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rsp_err_q <= rsp_err_d;
      own_mem_q <= own_mem_d;
    end
  end

endmodule

// File: tb/tb_soc_data_port_arbiter.sv
module tb_soc_data_port_arbiter;

  localparam logic [31:0] ADDR0 = 32'h1000_0000;
  localparam logic [31:0] ADDR1 = 32'h2000_0004;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_i, we_i, gnt_o, rvalid_o;
  logic [7:0]  be_i;
  logic [63:0] addr_i, wdata_i;
  logic [31:0] rdata_o, mst_addr_o, mst_wdata_o, mst_rdata_i;
  logic [3:0]  mst_be_o;
  logic        mst_req_o, mst_gnt_i, mst_we_o, mst_rvalid_i, rsp_err_o;

  always #5 clk = ~clk;

  soc_data_port_arbiter #(.N_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2)) dut (
    .clk_i(clk), .reset_i(rst), .req_i(req_i), .we_i(we_i), .be_i(be_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .mst_req_o(mst_req_o), .mst_gnt_i(mst_gnt_i), .mst_we_o(mst_we_o), .mst_be_o(mst_be_o),
    .mst_addr_o(mst_addr_o), .mst_wdata_o(mst_wdata_o), .mst_rvalid_i(mst_rvalid_i),
    .mst_rdata_i(mst_rdata_i), .rsp_err_o(rsp_err_o)
  );

  typedef struct packed { logic [1:0] vec; logic [31:0] val; } exp_t;
  exp_t gnt_q[$];
  exp_t rsp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected grant/response whenever the DUT presents one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (gnt_o != 2'b00) begin
          if (gnt_q.size() == 0) chk("unexpected_gnt", {30'd0, gnt_o}, 32'd0);
          else begin
            e = gnt_q.pop_front();
            chk("gnt_vec", {30'd0, gnt_o}, {30'd0, e.vec});
            chk("gnt_addr", mst_addr_o, e.val);
          end
        end
        if (rvalid_o != 2'b00) begin
          if (rsp_q.size() == 0) chk("unexpected_rvalid", {30'd0, rvalid_o}, 32'd0);
          else begin
            e = rsp_q.pop_front();
            chk("rvalid_vec", {30'd0, rvalid_o}, {30'd0, e.vec});
            chk("rdata", rdata_o, e.val);
          end
        end
      end
    end
  end

  task automatic drive(input logic [1:0] r, input logic g, input logic rv, input logic [31:0] rd);
    req_i = r; mst_gnt_i = g; mst_rvalid_i = rv; mst_rdata_i = rd;
  endtask

  task automatic exp_gnt(input logic [1:0] v, input logic [31:0] a);
    gnt_q.push_back({v, a});
  endtask

  task automatic exp_rsp(input logic [1:0] v, input logic [31:0] d);
    rsp_q.push_back({v, d});
  endtask

  task automatic to_neg;
    @(negedge clk);
  endtask

  task automatic next;
    @(posedge clk);
    #1;
  endtask

  logic [1:0] pat [20] = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10,
                           2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    logic [1:0] prev;
    rst = 1'b1;
    drive(2'b00, 1'b0, 1'b0, 32'd0);
    addr_i  = {ADDR1, ADDR0};
    we_i    = 2'b10;
    be_i    = 8'hF3;
    wdata_i = {32'hBBBB_0001, 32'hAAAA_0000};

    // Reset state
    to_neg;
    chk("rst_gnt", {30'd0, gnt_o}, 32'd0);
    chk("rst_rvalid", {30'd0, rvalid_o}, 32'd0);
    chk("rst_mst_req", {31'd0, mst_req_o}, 32'd0);
    chk("rst_err", {31'd0, rsp_err_o}, 32'd0);
    next;
    rst = 1'b0;

    // T1: single grant, same-cycle, payload from slice 0
    drive(2'b01, 1'b1, 1'b0, 32'd0); exp_gnt(2'b01, ADDR0);
    to_neg;
    chk("t1_mst_req", {31'd0, mst_req_o}, 32'd1);
    chk("t1_we", {31'd0, mst_we_o}, 32'd0);
    chk("t1_be", {28'd0, mst_be_o}, 32'h3);
    chk("t1_wdata", mst_wdata_o, 32'hAAAA_0000);
    next;
    drive(2'b00, 1'b0, 1'b1, 32'h1111_0001); exp_rsp(2'b01, 32'h1111_0001);
    to_neg; next;

    // T2: both requesting, alternating grants (rr_ptr=1 after T1)
    drive(2'b11, 1'b1, 1'b0, 32'd0); exp_gnt(2'b10, ADDR1);
    to_neg;
    chk("t2_we1", {31'd0, mst_we_o}, 32'd1);
    chk("t2_be1", {28'd0, mst_be_o}, 32'hF);
    next;
    drive(2'b11, 1'b1, 1'b1, 32'h2222_0001); exp_gnt(2'b01, ADDR0); exp_rsp(2'b10, 32'h2222_0001);
    to_neg; next;
    drive(2'b11, 1'b1, 1'b1, 32'h2222_0002); exp_gnt(2'b10, ADDR1); exp_rsp(2'b01, 32'h2222_0002);
    to_neg; next;
    drive(2'b11, 1'b1, 1'b1, 32'h2222_0003); exp_gnt(2'b01, ADDR0); exp_rsp(2'b10, 32'h2222_0003);
    to_neg; next;
    drive(2'b00, 1'b0, 1'b1, 32'h2222_0004); exp_rsp(2'b01, 32'h2222_0004);
    to_neg; next;

    // T3: req0 locked while gnt low; req1 (favoured by rr_ptr=1) must not pre-empt
    drive(2'b01, 1'b0, 1'b0, 32'd0);
    to_neg; chk("t3_addr_c1", mst_addr_o, ADDR0); next;
    drive(2'b11, 1'b0, 1'b0, 32'd0);
    to_neg; chk("t3_addr_c2", mst_addr_o, ADDR0); next;
    to_neg; chk("t3_addr_c3", mst_addr_o, ADDR0); next;
    drive(2'b11, 1'b1, 1'b0, 32'd0); exp_gnt(2'b01, ADDR0);
    to_neg; next;
    drive(2'b11, 1'b1, 1'b0, 32'd0); exp_gnt(2'b10, ADDR1);
    to_neg; next;
    drive(2'b00, 1'b0, 1'b1, 32'h3333_0001); exp_rsp(2'b01, 32'h3333_0001);
    to_neg; next;
    drive(2'b00, 1'b0, 1'b1, 32'h3333_0002); exp_rsp(2'b10, 32'h3333_0002);
    to_neg; next;

    // T4: fill the owner FIFO, request blocked while full
    drive(2'b11, 1'b1, 1'b0, 32'd0); exp_gnt(2'b01, ADDR0);
    to_neg; next;
    drive(2'b11, 1'b1, 1'b0, 32'd0); exp_gnt(2'b10, ADDR1);
    to_neg; next;
    drive(2'b11, 1'b1, 1'b0, 32'd0);
    to_neg; chk("t4_full_req", {31'd0, mst_req_o}, 32'd0); next;
    drive(2'b11, 1'b1, 1'b1, 32'h4444_0001); exp_rsp(2'b01, 32'h4444_0001);
    to_neg; chk("t4_full_pop_req", {31'd0, mst_req_o}, 32'd0); next;
    drive(2'b11, 1'b1, 1'b0, 32'd0); exp_gnt(2'b01, ADDR0);
    to_neg; chk("t4_resume_req", {31'd0, mst_req_o}, 32'd1); next;
    drive(2'b00, 1'b0, 1'b1, 32'h4444_0002); exp_rsp(2'b10, 32'h4444_0002);
    to_neg; next;
    drive(2'b00, 1'b0, 1'b1, 32'h4444_0003); exp_rsp(2'b01, 32'h4444_0003);
    to_neg; next;

    // T5: simultaneous push/pop at count=1 across pointer wrap
    drive(2'b01, 1'b1, 1'b0, 32'd0); exp_gnt(2'b01, ADDR0);
    to_neg; next;
    prev = 2'b01;
    for (int i = 0; i < 20; i++) begin
      drive(pat[i], 1'b1, 1'b1, 32'hC000_0000 + i);
      exp_gnt(pat[i], (pat[i] == 2'b01) ? ADDR0 : ADDR1);
      exp_rsp(prev, 32'hC000_0000 + i);
      to_neg; chk("t5_not_full", {31'd0, mst_req_o}, 32'd1); next;
      prev = pat[i];
    end
    drive(2'b00, 1'b0, 1'b1, 32'hC000_00FF); exp_rsp(prev, 32'hC000_00FF);
    to_neg; next;

    // T6: orphan response sets sticky error
    drive(2'b00, 1'b0, 1'b1, 32'hDEAD_0001);
    to_neg;
    chk("t6_orphan_rvalid", {30'd0, rvalid_o}, 32'd0);
    chk("t6_err_before", {31'd0, rsp_err_o}, 32'd0);
    next;
    drive(2'b00, 1'b0, 1'b0, 32'd0);
    to_neg; chk("t6_err_set", {31'd0, rsp_err_o}, 32'd1); next;
    to_neg; chk("t6_err_sticky", {31'd0, rsp_err_o}, 32'd1); next;
    // outstanding transaction plus HOLD on requester 1, then reset
    drive(2'b01, 1'b1, 1'b0, 32'd0); exp_gnt(2'b01, ADDR0);
    to_neg; next;
    drive(2'b10, 1'b0, 1'b0, 32'd0);
    to_neg; next;
    rst = 1'b1;
    to_neg;
    chk("t6_rst_err", {31'd0, rsp_err_o}, 32'd0);
    chk("t6_rst_req", {31'd0, mst_req_o}, 32'd1);
    next;
    rst = 1'b0;
    // pre-reset transaction is forgotten: its response is orphaned
    drive(2'b00, 1'b0, 1'b1, 32'hDEAD_0002);
    to_neg; chk("t6_post_rst_rvalid", {30'd0, rvalid_o}, 32'd0); next;
    drive(2'b11, 1'b1, 1'b0, 32'd0); exp_gnt(2'b01, ADDR0);
    to_neg; chk("t6_err_again", {31'd0, rsp_err_o}, 32'd1); next;
    drive(2'b00, 1'b0, 1'b1, 32'hE000_0001); exp_rsp(2'b01, 32'hE000_0001);
    to_neg; next;
    drive(2'b00, 1'b0, 1'b0, 32'd0);
    to_neg;

    chk("gnt_q_drained", gnt_q.size(), 32'd0);
    chk("rsp_q_drained", rsp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
